// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Load-type codes carried on RegWriteM
  localparam logic [2:0] LB  = 3'd1;
  localparam logic [2:0] LH  = 3'd2;
  localparam logic [2:0] LW  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  // Timeout counter width for the default timeout
  localparam int TIMEOUT_CYCLES_DFLT = 64;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES_DFLT);

  // Counter width for an arbitrary timeout; at least one bit
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Access size comes from the load type for loads and from the byte mask for stores
  function automatic logic is_misaligned(input logic       is_ld,
                                         input logic [2:0] lt,
                                         input logic [3:0] mask,
                                         input logic [1:0] off);
    logic half;
    logic word;
    half = is_ld ? ((lt == LH) || (lt == LHU)) : (mask == 4'b0011);
    word = is_ld ? (lt == LW) : (mask == 4'b1111);
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/halfword/word of a read word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
module load_extender
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Lane select then extension; unknown types pass the full word through
  always_comb begin
    sel_b  = word[{offset, 3'b000} +: 8];
    sel_h  = offset[1] ? word[31:16] : word[15:0];
    result = word;
    case (ld_type)
      LB:      result = {{24{sel_b[7]}}, sel_b};
      LBU:     result = {24'h0, sel_b};
      LH:      result = {{16{sel_h[15]}}, sel_h};
      LHU:     result = {16'h0, sel_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one word-aligned req/ack access per instruction, extended load data out.
// Latency: req 1 cycle after access seen; min 3 stalled-to-advance cycles (IDLE, WAIT, DONE), abort after TIMEOUT_CYCLES WAIT cycles.
// Backpressure: StallM freezes the pipeline while an access is starting or outstanding; MEM_MISALIGN_CHK_EN adds MisalignM and the alignment check.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] LOAD_DATA_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  input  logic [3:0]  MemWriteM,
  input  logic        MemToRegM,
  input  logic [2:0]  RegWriteM,
  input  logic        ClearM,
  output logic        MemReq,
  output logic [3:0]  MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        StallM,
  output logic [31:0] LoadDataM,
  output logic        BusErrM
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        MisalignM
`endif
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_load;
  logic [2:0]       lat_type;
  logic [1:0]       lat_off;
  logic             access;
  logic             bad_align;
  logic [1:0]       off;
  logic [31:0]      ext_data;

  assign off    = AluOutM[1:0];
  assign access = (MemToRegM | (|MemWriteM)) & ~ClearM;
  // Stall covers the cycle the access is seen plus every outstanding cycle; DONE lets the pipe advance
  assign StallM = ((state == IDLE) & access) | (state == WAIT);

`ifdef MEM_MISALIGN_CHK_EN
  assign bad_align = is_misaligned(MemToRegM, RegWriteM, MemWriteM, off);
`else
  assign bad_align = 1'b0;
`endif

  load_extender u_ext (
    .word    (MemRData),
    .offset  (lat_off),
    .ld_type (lat_type),
    .result  (ext_data)
  );

  // Access FSM with registered memory-port outputs, result and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_load  <= 1'b0;
      lat_type  <= 3'd0;
      lat_off   <= 2'b00;
      MemReq    <= 1'b0;
      MemWe     <= 4'h0;
      MemAddr   <= 32'h0;
      MemWData  <= 32'h0;
      LoadDataM <= LOAD_DATA_RST;
      BusErrM   <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      MisalignM <= 1'b0;
`endif
    end else begin
      BusErrM <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      MisalignM <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access && bad_align) begin
            // Rejected before reaching the bus: no request, result forced to the abort value
            LoadDataM <= LOAD_DATA_RST;
`ifdef MEM_MISALIGN_CHK_EN
            MisalignM <= 1'b1;
`endif
            state     <= DONE;
          end else if (access) begin
            // Enables shifted past lane 3 fall off the 4-bit vector rather than wrapping
            MemAddr  <= {AluOutM[31:2], 2'b00};
            MemWe    <= MemWriteM << off;
            MemWData <= StoreDataM << {off, 3'b000};
            lat_load <= MemToRegM;
            lat_type <= RegWriteM;
            lat_off  <= off;
            cnt      <= '0;
            MemReq   <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // ClearM is not looked at here: an issued access always runs to completion
          if (MemAck) begin
            MemReq <= 1'b0;
            if (lat_load) begin
              LoadDataM <= ext_data;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            MemReq    <= 1'b0;
            LoadDataM <= LOAD_DATA_RST;
            BusErrM   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Pipeline advances this cycle; the same instruction is still on the inputs, so never retrigger
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests queued at drive time, checked when MemReq appears.
// Latency: n/a.
// Backpressure: the bench acts as the data memory and answers MemReq with a programmable ack delay.
module tb_mem_access_unit;

  localparam int          TO      = 4;
  localparam logic [31:0] LD_RST  = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] AluOutM = '0;
  logic [31:0] StoreDataM = '0;
  logic [3:0]  MemWriteM = '0;
  logic        MemToRegM = 1'b0;
  logic [2:0]  RegWriteM = '0;
  logic        ClearM = 1'b0;
  logic        MemReq;
  logic [3:0]  MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;
  logic        StallM;
  logic [31:0] LoadDataM;
  logic        BusErrM;
`ifdef MEM_MISALIGN_CHK_EN
  logic        MisalignM;
`endif

  int   checks = 0;
  int   errors = 0;
  req_t exp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .LOAD_DATA_RST(LD_RST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AluOutM    (AluOutM),
    .StoreDataM (StoreDataM),
    .MemWriteM  (MemWriteM),
    .MemToRegM  (MemToRegM),
    .RegWriteM  (RegWriteM),
    .ClearM     (ClearM),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .MemAck     (MemAck),
    .StallM     (StallM),
    .LoadDataM  (LoadDataM),
    .BusErrM    (BusErrM)
`ifdef MEM_MISALIGN_CHK_EN
    ,
    .MisalignM  (MisalignM)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference extension: shift the addressed lane down to bit 0, then extend
  function automatic logic [31:0] model_ld(input logic [31:0] w, input logic [1:0] o, input logic [2:0] t);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = w >> (8 * int'(o));
    sh = w >> (16 * int'(o[1]));
    case (t)
      3'd1:    return {{24{sb[7]}}, sb[7:0]};
      3'd4:    return {24'h0, sb[7:0]};
      3'd2:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Drive one instruction, act as memory, and check request, stall length, result and error pulse
  task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [3:0] mask, input logic ld, input logic [2:0] lt,
                        input logic [31:0] rdata, input int ack_at, input bit exp_req,
                        input logic [31:0] exp_addr, input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_ld, input int exp_stall, input logic exp_berr);
    int   stall_n;
    int   req_n;
    bit   done;
    req_t e;
    req_t got;
    @(posedge clk); #1;
    AluOutM    = addr;
    StoreDataM = sdata;
    MemWriteM  = mask;
    MemToRegM  = ld;
    RegWriteM  = lt;
    if (exp_req) begin
      e.addr  = exp_addr;
      e.we    = exp_we;
      e.wdata = exp_wdata;
      exp_q.push_back(e);
    end
    stall_n = 0;
    req_n   = 0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (StallM) begin
        stall_n++;
        if (MemReq) begin
          req_n++;
          if (req_n == 1) begin
            if (exp_q.size() == 0) begin
              check_eq({tag, "_unexpected_req"}, 32'(MemReq), 32'd0);
            end else begin
              got = exp_q.pop_front();
              check_eq({tag, "_addr"},  MemAddr, got.addr);
              check_eq({tag, "_we"},    32'(MemWe), 32'(got.we));
              check_eq({tag, "_wdata"}, MemWData, got.wdata);
            end
          end
          if (req_n == ack_at) begin
            MemAck   = 1'b1;
            MemRData = rdata;
          end
        end
        @(posedge clk); #1;
        MemAck = 1'b0;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) check_eq({tag, "_no_done"}, 32'd0, 32'd1);
    check_eq({tag, "_stall"},  32'(stall_n), 32'(exp_stall));
    check_eq({tag, "_ld"},     LoadDataM, exp_ld);
    check_eq({tag, "_berr"},   32'(BusErrM), 32'(exp_berr));
    check_eq({tag, "_reqidle"}, 32'(MemReq), 32'd0);
    if (!exp_req) check_eq({tag, "_reqcnt"}, 32'(req_n), 32'd0);
`ifdef MEM_MISALIGN_CHK_EN
    check_eq({tag, "_mis"}, 32'(MisalignM), 32'(!exp_req));
`endif
    @(posedge clk); #1;
    AluOutM    = '0;
    StoreDataM = '0;
    MemWriteM  = '0;
    MemToRegM  = 1'b0;
    RegWriteM  = '0;
    check_eq({tag, "_berr_pulse"}, 32'(BusErrM), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  t;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] w;
    int          ak;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check_eq("rst_req",   32'(MemReq), 32'd0);
    check_eq("rst_we",    32'(MemWe), 32'd0);
    check_eq("rst_addr",  MemAddr, 32'h0);
    check_eq("rst_wdata", MemWData, 32'h0);
    check_eq("rst_ld",    LoadDataM, LD_RST);
    check_eq("rst_berr",  32'(BusErrM), 32'd0);
    check_eq("rst_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed loads and stores
    run_op("lw100", 32'h100, 32'h0, 4'h0, 1'b1, 3'd3, 32'hDEADBEEF, 2, 1'b1,
           32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    run_op("lb103", 32'h103, 32'h0, 4'h0, 1'b1, 3'd1, 32'h80FF0000, 1, 1'b1,
           32'h100, 4'h0, 32'h0, 32'hFFFFFF80, 2, 1'b0);
    run_op("lbu103", 32'h103, 32'h0, 4'h0, 1'b1, 3'd4, 32'h80FF0000, 1, 1'b1,
           32'h100, 4'h0, 32'h0, 32'h00000080, 2, 1'b0);
    run_op("lh102", 32'h102, 32'h0, 4'h0, 1'b1, 3'd2, 32'h80FF0000, 3, 1'b1,
           32'h100, 4'h0, 32'h0, 32'hFFFF80FF, 4, 1'b0);
    run_op("lhu102", 32'h102, 32'h0, 4'h0, 1'b1, 3'd5, 32'h80FF0000, 1, 1'b1,
           32'h100, 4'h0, 32'h0, 32'h000080FF, 2, 1'b0);
    // Stores leave the previous load result in place
    run_op("sb101", 32'h101, 32'h000000AB, 4'b0001, 1'b0, 3'd0, 32'hFFFFFFFF, 1, 1'b1,
           32'h100, 4'b0010, 32'h0000AB00, 32'h000080FF, 2, 1'b0);
    run_op("sw200", 32'h200, 32'h12345678, 4'b1111, 1'b0, 3'd0, 32'h0, 2, 1'b1,
           32'h200, 4'b1111, 32'h12345678, 32'h000080FF, 3, 1'b0);
    // No ack: abort after TO WAIT cycles with the reset value and a one-cycle error pulse
    run_op("lw_to", 32'h300, 32'h0, 4'h0, 1'b1, 3'd3, 32'h55555555, -1, 1'b1,
           32'h300, 4'h0, 32'h0, LD_RST, 1 + TO, 1'b1);

`ifdef MEM_MISALIGN_CHK_EN
    run_op("lw102_mis", 32'h102, 32'h0, 4'h0, 1'b1, 3'd3, 32'hCAFEF00D, 1, 1'b0,
           32'h0, 4'h0, 32'h0, LD_RST, 1, 1'b0);
    run_op("sh203_mis", 32'h203, 32'h0000BEEF, 4'b0011, 1'b0, 3'd0, 32'h0, 1, 1'b0,
           32'h0, 4'h0, 32'h0, LD_RST, 1, 1'b0);
`else
    run_op("lw102", 32'h102, 32'h0, 4'h0, 1'b1, 3'd3, 32'hCAFEF00D, 1, 1'b1,
           32'h100, 4'h0, 32'h0, 32'hCAFEF00D, 2, 1'b0);
    // Upper enable lane is dropped, data shifted out of range is lost
    run_op("sh203", 32'h203, 32'h0000BEEF, 4'b0011, 1'b0, 3'd0, 32'h0, 1, 1'b1,
           32'h200, 4'b1000, 32'hEF000000, 32'hCAFEF00D, 2, 1'b0);
`endif

    // Randomised aligned loads against the reference extension
    for (int i = 0; i < 8; i++) begin
      t  = 3'($urandom_range(1, 5));
      if (t == 3'd3)                   o = 2'b00;
      else if (t == 3'd2 || t == 3'd5) o = {1'($urandom_range(0, 1)), 1'b0};
      else                             o = 2'($urandom_range(0, 3));
      a  = {$urandom() & 32'hFFFF_FFFC} | {30'h0, o};
      w  = $urandom();
      ak = $urandom_range(1, 3);
      run_op($sformatf("rnd%0d", i), a, 32'h0, 4'h0, 1'b1, t, w, ak, 1'b1,
             {a[31:2], 2'b00}, 4'h0, 32'h0, model_ld(w, o, t), 1 + ak, 1'b0);
    end

    // Reset while an access is outstanding, then a stale ack
    @(posedge clk); #1;
    AluOutM = 32'h400; MemToRegM = 1'b1; RegWriteM = 3'd3;
    @(negedge clk);
    @(negedge clk);
    check_eq("rstw_req_before", 32'(MemReq), 32'd1);
    AluOutM = '0; MemToRegM = 1'b0; RegWriteM = '0;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_req",   32'(MemReq), 32'd0);
    check_eq("rstw_ld",    LoadDataM, LD_RST);
    check_eq("rstw_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    MemAck = 1'b1; MemRData = 32'h13579BDF;
    @(posedge clk); #1;
    MemAck = 1'b0;
    @(negedge clk);
    check_eq("stale_req",   32'(MemReq), 32'd0);
    check_eq("stale_stall", 32'(StallM), 32'd0);
    check_eq("stale_ld",    LoadDataM, LD_RST);
    check_eq("stale_berr",  32'(BusErrM), 32'd0);

    // ClearM blocks a start in IDLE
    @(posedge clk); #1;
    AluOutM = 32'h500; MemToRegM = 1'b1; RegWriteM = 3'd3; ClearM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("clr_req%0d", i),   32'(MemReq), 32'd0);
      check_eq($sformatf("clr_stall%0d", i), 32'(StallM), 32'd0);
    end
    @(posedge clk); #1;
    AluOutM = '0; MemToRegM = 1'b0; RegWriteM = '0; ClearM = 1'b0;

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
